// File: rtl/reg_issue_scoreboard_if.sv
// rtl/reg_issue_scoreboard_if.sv - fetch, writeback and issue signal bundle for reg_issue_scoreboard
//
// Purpose: groups every non-clock, non-reset signal of the issue stage.
//   master : upstream/downstream environment (drives instr, flush, wb, iss_ready)
//   slave  : the issue stage itself
// Signals:
//   instr/instr_valid/instr_ready  fetched word handshake
//   flush                          drop held instruction
//   wb_en/wb_rd                    writeback clearing a pending bit
//   iss_valid/iss_ready            issue handshake
//   iss_rs1/iss_rs2/iss_rd/iss_we  register file port addresses and write enable
//   iss_instr                      raw held instruction
//   stall_cnt                      saturating hazard-stall cycle count
interface reg_issue_scoreboard_if #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int STALL_CW = 16
);
  logic [XLEN-1:0]     instr;
  logic                instr_valid;
  logic                instr_ready;
  logic                flush;
  logic                wb_en;
  logic [REG_AW-1:0]   wb_rd;
  logic                iss_valid;
  logic                iss_ready;
  logic [REG_AW-1:0]   iss_rs1;
  logic [REG_AW-1:0]   iss_rs2;
  logic [REG_AW-1:0]   iss_rd;
  logic                iss_we;
  logic [XLEN-1:0]     iss_instr;
  logic [STALL_CW-1:0] stall_cnt;

  modport master (
    output instr, instr_valid, flush, wb_en, wb_rd, iss_ready,
    input  instr_ready, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_we, iss_instr, stall_cnt
  );

  modport slave (
    input  instr, instr_valid, flush, wb_en, wb_rd, iss_ready,
    output instr_ready, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_we, iss_instr, stall_cnt
  );
endinterface

// File: rtl/reg_issue_scoreboard.sv
// rtl/reg_issue_scoreboard.sv - decode/issue stage with RAW/WAW pending-write scoreboard
//
// Purpose: holds one fetched instruction, decodes rs1/rs2/rd and source/dest usage,
//   stalls while a used source or the destination has a write in flight, and marks
//   the destination pending when the instruction issues. x0 is never pending.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    reg_issue_scoreboard_if.slave (instr, flush, writeback, issue, stall_cnt)
// Optional feature: WB_BYPASS_EN - a register written back this cycle no longer
//   counts as pending for the hazard check (write-first register file).
module reg_issue_scoreboard #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int STALL_CW = 16
) (
  input logic                  clk,
  input logic                  reset,
  reg_issue_scoreboard_if.slave bus
);
  localparam int NREG = 1 << REG_AW;

  logic                held;
  logic [NREG-1:0]     pend;
  logic [NREG-1:0]     pend_next;
  logic [NREG-1:0]     pend_chk;
  logic [NREG-1:0]     wb_clr;
  logic [XLEN-1:0]     instr_q;
  logic [REG_AW-1:0]   rs1_q, rs2_q, rd_q;
  logic                use1_q, use2_q, we_q;
  logic [STALL_CW-1:0] stall_q;
  logic                dec_use1, dec_use2, dec_we;
  logic                hazard, valid, fire, ready, accept;

  // Source/destination usage by opcode class; rd==x0 never writes.
  always_comb begin
    dec_use1 = 1'b0;
    dec_use2 = 1'b0;
    dec_we   = 1'b0;
    case (bus.instr[6:0])
      7'b0110011:                         {dec_use1, dec_use2, dec_we} = 3'b111;
      7'b0010011, 7'b0000011, 7'b1100111: {dec_use1, dec_use2, dec_we} = 3'b101;
      7'b0100011, 7'b1100011:             {dec_use1, dec_use2, dec_we} = 3'b110;
      7'b1101111, 7'b0110111, 7'b0010111: {dec_use1, dec_use2, dec_we} = 3'b001;
      default:                            {dec_use1, dec_use2, dec_we} = 3'b000;
    endcase
    if (bus.instr[7 +: REG_AW] == '0) dec_we = 1'b0;
  end

  always_comb begin
    wb_clr = '0;
    if (bus.wb_en && (bus.wb_rd != '0)) wb_clr[bus.wb_rd] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  assign pend_chk = pend & ~wb_clr;
`else
  assign pend_chk = pend;
`endif

  assign hazard = (use1_q && pend_chk[rs1_q]) || (use2_q && pend_chk[rs2_q]) ||
                  (we_q && pend_chk[rd_q]);
  assign valid  = held && !hazard;
  // A flush cancels the issue even though iss_valid is shown this cycle.
  assign fire   = valid && bus.iss_ready && !bus.flush;
  assign ready  = !held || fire;
  assign accept = bus.instr_valid && ready && !bus.flush;

  // Clear first, then set, so a same-index set wins over a writeback clear.
  always_comb begin
    pend_next = pend & ~wb_clr;
    if (fire && we_q) pend_next[rd_q] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held    <= 1'b0;
      pend    <= '0;
      stall_q <= '0;
      instr_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      use1_q  <= 1'b0;
      use2_q  <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      pend <= pend_next;
      if (held && hazard && !bus.flush && (stall_q != '1))
        stall_q <= stall_q + STALL_CW'(1);
      if (bus.flush) begin
        held <= 1'b0;
      end else if (accept) begin
        held    <= 1'b1;
        instr_q <= bus.instr;
        rs1_q   <= bus.instr[15 +: REG_AW];
        rs2_q   <= bus.instr[20 +: REG_AW];
        rd_q    <= bus.instr[7 +: REG_AW];
        use1_q  <= dec_use1;
        use2_q  <= dec_use2;
        we_q    <= dec_we;
      end else if (fire) begin
        held <= 1'b0;
      end
    end
  end

  assign bus.iss_valid   = valid;
  assign bus.instr_ready = ready;
  assign bus.iss_rs1     = rs1_q;
  assign bus.iss_rs2     = rs2_q;
  assign bus.iss_rd      = rd_q;
  assign bus.iss_we      = we_q;
  assign bus.iss_instr   = instr_q;
  assign bus.stall_cnt   = stall_q;
endmodule

// File: tb/tb_reg_issue_scoreboard.sv
// tb/tb_reg_issue_scoreboard.sv - scoreboard bench for reg_issue_scoreboard
module tb_reg_issue_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reg_issue_scoreboard_if bus ();
  reg_issue_scoreboard dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { bit valid; bit ready; int stall; } cyc_t;
  typedef struct { logic [31:0] instr; int rs1; int rs2; int rd; bit we; } iss_t;

  cyc_t cyc_q[$];
  iss_t iss_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   dut_fires = 0;

  // Reference state: pending set, held instruction, stall counter.
  bit          m_pend[32];
  bit          m_held;
  logic [31:0] m_instr;
  int          m_stall;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void classify(input logic [31:0] w, output bit u1, output bit u2, output bit wr);
    logic [6:0] op;
    bit r, alu_like, st_br, wonly;
    op       = w[6:0];
    r        = (op == 7'b0110011);
    alu_like = (op == 7'b0010011) || (op == 7'b0000011) || (op == 7'b1100111);
    st_br    = (op == 7'b0100011) || (op == 7'b1100011);
    wonly    = (op == 7'b1101111) || (op == 7'b0110111) || (op == 7'b0010111);
    u1 = r || alu_like || st_br;
    u2 = r || st_br;
    wr = (r || alu_like || wonly) && (w[11:7] != 5'd0);
  endfunction

  function automatic logic [31:0] gen();
    logic [6:0]  ops [0:11];
    logic [31:0] w;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b0001111, 7'b0110011};
    w = $urandom();
    w[6:0]   = ops[$urandom_range(11)];
    w[11:7]  = 5'($urandom_range(7));
    w[19:15] = 5'($urandom_range(7));
    w[24:20] = 5'($urandom_range(7));
    return w;
  endfunction

  // One clock cycle: drive inputs, predict, push expectations, advance the model.
  task automatic step(input bit iv, input logic [31:0] iw, input bit rdy, input bit fl,
                      input bit wbe, input int wbr);
    bit u1, u2, wr, hz, v, f, rd_ok;
    bit eff[32];
    int r1, r2, rdx;
    cyc_t c;
    iss_t e;
    bus.instr_valid = iv;
    bus.instr       = iw;
    bus.iss_ready   = rdy;
    bus.flush       = fl;
    bus.wb_en       = wbe;
    bus.wb_rd       = wbr[4:0];
    eff = m_pend;
`ifdef WB_BYPASS_EN
    if (wbe) eff[wbr] = 1'b0;
`endif
    classify(m_instr, u1, u2, wr);
    r1  = int'(m_instr[19:15]);
    r2  = int'(m_instr[24:20]);
    rdx = int'(m_instr[11:7]);
    hz    = (u1 && eff[r1]) || (u2 && eff[r2]) || (wr && eff[rdx]);
    v     = m_held && !hz;
    f     = v && rdy && !fl;
    rd_ok = !m_held || f;
    c.valid = v; c.ready = rd_ok; c.stall = m_stall;
    cyc_q.push_back(c);
    if (f) begin
      e.instr = m_instr; e.rs1 = r1; e.rs2 = r2; e.rd = rdx; e.we = wr;
      iss_q.push_back(e);
    end
    @(posedge clk);
    if (wbe && wbr != 0) m_pend[wbr] = 1'b0;
    if (f && wr) m_pend[rdx] = 1'b1;
    if (m_held && hz && !fl && m_stall < 65535) m_stall++;
    if (fl) m_held = 1'b0;
    else if (iv && rd_ok) begin m_held = 1'b1; m_instr = iw; end
    else if (f) m_held = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc_t c;
    reset = 1'b0;
    bus.instr_valid = 1'b0; bus.flush = 1'b0; bus.wb_en = 1'b0; bus.iss_ready = 1'b0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_held = 1'b0; m_instr = '0; m_stall = 0;
    c.valid = 1'b0; c.ready = 1'b1; c.stall = 0;
    cyc_q.push_back(c);
    #1;
    check("rst_iss_rs1", bus.iss_rs1, 0);
    check("rst_iss_rd", bus.iss_rd, 0);
    check("rst_iss_we", bus.iss_we, 0);
    check("rst_iss_instr", bus.iss_instr, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Hold a probe reading xk (rd=x0) and see whether it is blocked.
  task automatic probe_pend(input logic [31:0] expv, input string tag);
    logic [31:0] p;
    for (int k = 0; k < 12; k++) begin
      p = (32'(k) << 15) | 32'h33;
      step(1, p, 0, 0, 0, 0);
      #1;
      check($sformatf("%s_x%0d_blocked", tag, k), !bus.iss_valid, expv[k]);
      step(0, 0, 0, 1, 0, 0);
    end
  endtask

  // Monitor: compare per-cycle expectations and every observed issue.
  cyc_t mc;
  iss_t me;
  initial forever begin
    @(negedge clk);
    #2;
    if (cyc_q.size() > 0) begin
      mc = cyc_q.pop_front();
      check("iss_valid", bus.iss_valid, mc.valid);
      check("instr_ready", bus.instr_ready, mc.ready);
      check("stall_cnt", bus.stall_cnt, mc.stall);
      if (bus.iss_valid && bus.iss_ready && !bus.flush) begin
        dut_fires++;
        if (iss_q.size() == 0) check("unexpected_issue", 1, 0);
        else begin
          me = iss_q.pop_front();
          check("iss_instr", bus.iss_instr, me.instr);
          check("iss_rs1", bus.iss_rs1, me.rs1);
          check("iss_rs2", bus.iss_rs2, me.rs2);
          check("iss_rd", bus.iss_rd, me.rd);
          check("iss_we", bus.iss_we, me.we);
        end
      end
    end
  end

  initial begin
    int f0;
    bus.instr = '0; bus.instr_valid = 0; bus.flush = 0; bus.wb_en = 0; bus.wb_rd = '0;
    bus.iss_ready = 0;
    @(negedge clk);
    do_reset();

    // nops never stall and never write
    for (int i = 0; i < 6; i++) step(1, 32'h00000013, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    probe_pend(32'h0, "nop_pend");

    // 8 independent addi x1..x8 back to back
    do_reset();
    f0 = dut_fires;
    for (int k = 1; k <= 8; k++) step(1, (32'(k) << 7) | 32'h00100013, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("stream_8_fires", dut_fires - f0, 8);
    probe_pend(32'h1FE, "stream_pend");

    // RAW stall on x5 released by writeback
    do_reset();
    step(1, 32'h00100293, 1, 0, 0, 0);
    step(1, 32'h00528333, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 5);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);

    // WAW on x7 flushed; sw x7 then stalls until x7 written back
    do_reset();
    step(1, 32'h00100393, 1, 0, 0, 0);
    step(1, 32'h0000A383, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(1, 32'h0070A023, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 7);
    step(0, 0, 1, 0, 0, 0);

    // reset mid-stream with x8..x11 pending and a stalled instruction held
    do_reset();
    for (int k = 8; k <= 11; k++) step(1, (32'(k) << 7) | 32'h00100013, 1, 0, 0, 0);
    step(1, 32'h00940633, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    do_reset();
    probe_pend(32'h0, "post_reset_pend");

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(3) != 0), gen(), ($urandom_range(3) != 0),
           ($urandom_range(15) == 0), ($urandom_range(2) == 0), int'($urandom_range(7)));

    // stall counter saturation
    do_reset();
    step(1, 32'h00100193, 1, 0, 0, 0);
    step(1, 32'h40318233, 1, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step(0, 0, 1, 0, 0, 0);
    #1;
    check("stall_saturated", bus.stall_cnt, 16'hFFFF);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);

    @(negedge clk);
    #3;
    check("issue_queue_drained", iss_q.size(), 0);
    check("cycle_queue_drained", cyc_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
